// File: rtl/dqn_pkg.sv
// Shared Q-format constants, action type and transition-FSM states for the DQN datapath.
package dqn_pkg;

   localparam int unsigned W     = 16;
   localparam int unsigned FRAC  = 10;
   localparam int unsigned N_ACT = 4;
   localparam int unsigned CNT_W = $clog2(N_ACT);

   typedef logic [1:0] act_t;

   typedef enum logic [1:0] {
      StIdle,
      StCur,
      StNxt,
      StDone
   } state_t;

endpackage

// File: rtl/q_argmax_unit.sv
// Running signed max/argmax over a serial stream of Q-value beats.
// Index 0 always reloads; later beats replace only on strictly greater, so ties keep the lower index.
module q_argmax_unit
   import dqn_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic [1:0]   i_idx,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_max,
   output logic [1:0]   o_arg
);

   logic [W-1:0] r_max;
   logic [1:0]   r_arg;
   logic         w_take;

   assign w_take = i_en && ((i_idx == 2'd0) || ($signed(i_data) > $signed(r_max)));

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_max <= '0;
         r_arg <= '0;
      end else if (w_take) begin
         r_max <= i_data;
         r_arg <= i_idx;
      end
   end

   assign o_max = r_max;
   assign o_arg = r_arg;

endmodule

// File: rtl/q_target_prep.sv
// Collects current- and next-state Q-values, producing Qt(act), maxQt1 and the greedy action.
// Optional `TERMINAL_Q_EN adds a terminal input that forces maxQt1 to zero for terminal transitions.
module q_target_prep
   import dqn_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   act,
`ifdef TERMINAL_Q_EN
   input  logic         terminal,
`endif
   input  logic         q_valid,
   input  logic [W-1:0] q_data,
   output logic         busy,
   output logic [W-1:0] Qt,
   output logic [W-1:0] maxQt1,
   output logic [1:0]   greedy_act,
   output logic         done
);

   state_t             r_state;
   state_t             w_state_d;
   logic [CNT_W-1:0]   r_cnt;
   logic [1:0]         r_act;
   logic [W-1:0]       r_qt_stage;
   logic [1:0]         r_greedy_stage;
   logic [W-1:0]       r_qt;
   logic [W-1:0]       r_max;
   logic [1:0]         r_greedy;
   logic               w_start_ok;
   logic               w_beat;
   logic               w_last;
   logic [W-1:0]       w_max;
   logic [1:0]         w_arg;
   logic [W-1:0]       w_max_fin;

   assign w_start_ok = (r_state == StIdle) && start;
   assign w_beat     = q_valid && ((r_state == StCur) || (r_state == StNxt));
   assign w_last     = (r_cnt == CNT_W'(N_ACT - 1));

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle: if (start) w_state_d = StCur;
         StCur:  if (w_beat && w_last) w_state_d = StNxt;
         StNxt:  if (w_beat && w_last) w_state_d = StDone;
         StDone: w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= StIdle;
         r_cnt          <= '0;
         r_act          <= '0;
         r_qt_stage     <= '0;
         r_greedy_stage <= '0;
         r_qt           <= '0;
         r_max          <= '0;
         r_greedy       <= '0;
      end else begin
         r_state <= w_state_d;
         if (w_start_ok) begin
            r_act <= act;
            r_cnt <= '0;
         end else if (w_beat) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
         end
         if ((r_state == StCur) && w_beat && (r_cnt == r_act)) r_qt_stage <= q_data;
         // The shared unit still holds the CUR argmax until NXT beat 0 reinitialises it.
         if ((r_state == StNxt) && w_beat && (r_cnt == '0)) r_greedy_stage <= w_arg;
         if (r_state == StDone) begin
            r_qt     <= r_qt_stage;
            r_max    <= w_max_fin;
            r_greedy <= r_greedy_stage;
         end
      end
   end

`ifdef TERMINAL_Q_EN
   logic r_term;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_term <= 1'b0;
      end else if (w_start_ok) begin
         r_term <= terminal;
      end
   end

   assign w_max_fin = r_term ? '0 : w_max;
`else
   assign w_max_fin = w_max;
`endif

   q_argmax_unit u_argmax (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_start_ok),
      .i_en   (w_beat),
      .i_idx  (r_cnt),
      .i_data (q_data),
      .o_max  (w_max),
      .o_arg  (w_arg)
   );

   // Staging is presented directly during DONE so results are valid alongside the strobe.
   assign busy       = (r_state != StIdle);
   assign done       = (r_state == StDone);
   assign Qt         = done ? r_qt_stage     : r_qt;
   assign maxQt1     = done ? w_max_fin      : r_max;
   assign greedy_act = done ? r_greedy_stage : r_greedy;

endmodule

// File: tb/tb_q_target_prep.sv
// Randomised scoreboard bench for q_target_prep; expected results come from a max/argmax model.
module tb_q_target_prep;

   typedef logic [15:0] beats4_t [4];

   typedef struct {
      logic [15:0] qt;
      logic [15:0] mx;
      logic [1:0]  g;
      int unsigned dcyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  act = '0;
   logic        terminal = 1'b0;
   logic        q_valid = 1'b0;
   logic [15:0] q_data = '0;
   logic        busy;
   logic [15:0] Qt;
   logic [15:0] maxQt1;
   logic [1:0]  greedy_act;
   logic        done;

   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   exp_t        sb[$];
   exp_t        last_exp;

   q_target_prep dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .act        (act),
`ifdef TERMINAL_Q_EN
      .terminal   (terminal),
`endif
      .q_valid    (q_valid),
      .q_data     (q_data),
      .busy       (busy),
      .Qt         (Qt),
      .maxQt1     (maxQt1),
      .greedy_act (greedy_act),
      .done       (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input beats4_t cur, input beats4_t nxt, input logic [1:0] a,
                                  input bit term, input int unsigned dcyc);
      exp_t e;
      int   best = 0;
      int   mx = $signed(nxt[0]);
      for (int k = 1; k < 4; k++) if ($signed(cur[k]) > $signed(cur[best])) best = k;
      for (int k = 1; k < 4; k++) if ($signed(nxt[k]) > mx) mx = $signed(nxt[k]);
      e.qt   = cur[a];
      e.g    = 2'(best);
      e.mx   = term ? 16'h0000 : 16'(mx);
      e.dcyc = dcyc;
      return e;
   endfunction

   function automatic logic [15:0] rnd_q();
      case ($urandom_range(0, 5))
         0: return 16'h8000;
         1: return 16'h7FFF;
         2: return 16'h0C00;
         3: return 16'hFC00;
         default: return 16'($urandom);
      endcase
   endfunction

   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_cycle", cyc, e.dcyc);
            chk("Qt", 32'(Qt), 32'(e.qt));
            chk("maxQt1", 32'(maxQt1), 32'(e.mx));
            chk("greedy_act", 32'(greedy_act), 32'(e.g));
         end
      end
   end

   // nbeats < 8 leaves the pass unfinished, so nothing is expected.
   task automatic do_trans(input beats4_t cur, input beats4_t nxt, input logic [1:0] a,
                           input int gap, input bit noise, input bit term, input int nbeats);
      int unsigned n;
      bit          t_eff;
      @(posedge clk); #1;
      start = 1'b1; act = a; terminal = term; q_valid = 1'b0;
      n = cyc;
`ifdef TERMINAL_Q_EN
      t_eff = term;
`else
      t_eff = 1'b0;
`endif
      if (nbeats == 8) begin
         last_exp = model(cur, nxt, a, t_eff, n + 9 + 7 * gap);
         sb.push_back(last_exp);
      end
      for (int j = 0; j < nbeats; j++) begin
         @(posedge clk); #1;
         start = noise ? 1'($urandom) : 1'b0;
         act = 2'($urandom); terminal = 1'($urandom);
         q_valid = 1'b1;
         q_data = (j < 4) ? cur[j] : nxt[j - 4];
         if (j < nbeats - 1) begin
            for (int g = 0; g < gap; g++) begin
               @(posedge clk); #1;
               q_valid = 1'b0; q_data = 16'($urandom);
               start = noise ? 1'($urandom) : 1'b0;
            end
         end
      end
      @(posedge clk); #1;
      q_valid = 1'b0;
      start = noise;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic drain_and_hold();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      chk("sb_drain", 32'(sb.size()), 32'd0);
      sb.delete();
      @(negedge clk);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("hold_Qt", 32'(Qt), 32'(last_exp.qt));
      chk("hold_maxQt1", 32'(maxQt1), 32'(last_exp.mx));
      chk("hold_greedy", 32'(greedy_act), 32'(last_exp.g));
   endtask

   task automatic chk_reset_vals();
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_Qt", 32'(Qt), 32'd0);
      chk("rst_maxQt1", 32'(maxQt1), 32'd0);
      chk("rst_greedy", 32'(greedy_act), 32'd0);
   endtask

   initial begin
      beats4_t c;
      beats4_t x;
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      chk_reset_vals();

      // Beats while idle must be ignored.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         q_valid = 1'b1; q_data = 16'($urandom);
      end
      @(posedge clk); #1 q_valid = 1'b0;
      @(negedge clk);
      chk("idle_beats_busy", 32'(busy), 32'd0);

      c = '{16'h0400, 16'h0C00, 16'h1400, 16'hF800};
      x = '{16'h0800, 16'h1400, 16'h0400, 16'h0000};
      do_trans(c, x, 2'd2, 0, 1'b0, 1'b0, 8);
      drain_and_hold();

      c = '{16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00};
      x = '{16'h8000, 16'hF800, 16'hFC00, 16'h8001};
      do_trans(c, x, 2'd3, 0, 1'b0, 1'b0, 8);
      drain_and_hold();

      c = '{16'h0400, 16'h0C00, 16'h1400, 16'hF800};
      x = '{16'h0800, 16'h1400, 16'h0400, 16'h0000};
      do_trans(c, x, 2'd2, 3, 1'b1, 1'b0, 8);
      drain_and_hold();

      do_trans(c, x, 2'd1, 0, 1'b0, 1'b1, 8);
      drain_and_hold();

      do_trans(c, x, 2'd0, 1, 1'b1, 1'b0, 5);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      chk_reset_vals();
      last_exp.qt = '0; last_exp.mx = '0; last_exp.g = '0;
      do_trans(c, x, 2'd3, 0, 1'b0, 1'b0, 8);
      drain_and_hold();

      for (int t = 0; t < 25; t++) begin
         for (int k = 0; k < 4; k++) begin
            c[k] = rnd_q();
            x[k] = rnd_q();
         end
         do_trans(c, x, 2'($urandom), $urandom_range(0, 2), 1'($urandom), 1'($urandom), 8);
         drain_and_hold();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule

// File: doc/q_target_prep.md
Name: q_target_prep

Overview:
- Upstream feeder of the TD-error stage: collects the 4 output-layer Q-values for the current state, then the 4 for the next state.
- Produces Qt(act), maxQt1 and the greedy action, plus a 1-cycle done strobe aligned with controller step 7.
- Beats are streamed serially from the output-layer MAC, one per valid cycle.
- All data is signed Q6.10 (16-bit).

Parameters:
W, 16, Q-value width (signed fixed point)
FRAC, 10, fractional bits (informational; no rescaling inside block)
N_ACT, 4, number of actions / Q outputs per pass

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin a new transition; sampled only in IDLE
act  in  2  action taken at time t; latched on accepted start
q_valid  in  1  q_data beat valid
q_data  in  W  signed Q-value beat, action index implied by beat order 0..N_ACT-1
busy  out  1  high from accepted start until DONE exits
Qt  out  W  Q(s_t, act)
maxQt1  out  W  max over a of Q(s_t+1, a)
greedy_act  out  2  argmax over a of Q(s_t, a)
done  out  1  1-cycle pulse; outputs valid from this cycle until next done

Behaviour:
- Reset: state=IDLE; busy=0, done=0, Qt=0, maxQt1=0, greedy_act=0; beat counter=0.
- rst mid-operation aborts the pass with the same reset values. Partial results are discarded.
- FSM IDLE -> CUR -> NXT -> DONE -> IDLE.
- IDLE:
  - start=1 latches act, clears counter and enters CUR.
  - q_valid in IDLE is ignored.
- CUR:
  - Each q_valid beat: the counter selects index k.
  - If k==act_latched, the beat is captured into Qt staging.
  - Running max/argmax is updated with a strict greater-than compare, so ties keep the lower index.
  - Beat k=0 unconditionally initialises max/argmax.
  - After beat N_ACT-1: counter clears and the FSM enters NXT on the next cycle.
- NXT:
  - Same beat rules; running max only (argmax unused).
  - Beat 0 initialises; the last beat transitions to DONE.
- DONE, one cycle:
  - Output registers Qt/maxQt1/greedy_act load from staging.
  - done=1 in this cycle.
  - The next state is IDLE.
- Latency: done asserts exactly 1 cycle after the 8th accepted beat. With back-to-back beats, start to done = 9 cycles.
- q_valid gaps are allowed; the counter advances only on valid beats.
- start while busy is ignored. start in the DONE cycle is ignored; it must be reissued in IDLE.
- Outputs hold their last values outside DONE. Downstream stages may sample them at any time after done.
- Compare is signed full width, with no saturation; values pass through unmodified.
- Edge values: all-equal inputs give greedy_act=0. Most-negative 0x8000 inputs are handled correctly.

Optional Feature:
- Macro TERMINAL_Q_EN.
- Enabled:
  - Adds input port terminal (1 bit), latched with start.
  - If latched terminal=1, maxQt1 loads 0 in DONE; next-state beats are still consumed, so handshake timing is unchanged.
  - Qt and greedy_act are unaffected.
- Disabled: port absent; maxQt1 always equals the NXT-pass maximum.

Decomposition:
- Shared package dqn_pkg holds:
  - Q-format constants (W, FRAC)
  - N_ACT
  - the action typedef (2-bit)
  - the FSM state enum (IDLE, CUR, NXT, DONE)
- One sub-module: q_argmax_unit.
  - Contains the running max/argmax register pair with init and update enable.
  - Shared by the CUR and NXT passes via a clear on pass start.
- The top holds the FSM, beat counter, act latch and output registers.

Test Plan:
- Reset then start, act=2; CUR beats 0x0400,0x0C00,0x1400,0xF800; NXT beats 0x0800,0x1400,0x0400,0x0000. Required: done 9 cycles after start, Qt=0x1400, greedy_act=2, maxQt1=0x1400.
- Tie handling: CUR beats all 0x0C00, act=3. Required: greedy_act=0, Qt=0x0C00.
- All-negative NXT beats 0x8000,0xF800,0xFC00,0x8001. Required: maxQt1=0xFC00.
- q_valid with 3-cycle gaps between beats, plus start pulses during busy. Required: same results as the back-to-back run, done exactly once, start during busy ignored.
- rst asserted after the 5th beat. Required: outputs 0, busy=0. A following full transition produces correct fresh results.
- TERMINAL_Q_EN defined, terminal=1, NXT max 0x1400. Required: maxQt1=0x0000, Qt/greedy_act unchanged, done timing identical.
